// File: rtl/mem_dump.sv
// mem_dump: walks DRAM word indices FIRST_ADDR..LAST_ADDR after the CPU halts.
// Each word is presented on a valid/ready handshake.
// While active, if_end steers the DRAM address mux to this block's address.
// Every output is driven straight from a register.
module mem_dump #(
  parameter int unsigned FIRST_ADDR = 0,
  parameter int unsigned LAST_ADDR  = 127
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] ReadDataM,
  input  logic        dump_ready,
  output logic        if_end,
  output logic [6:0]  address,
  output logic        dump_valid,
  output logic [31:0] dump_data,
  output logic [6:0]  dump_addr,
  output logic        busy,
  output logic        done
);

  localparam logic [6:0] FIRST_A = 7'(FIRST_ADDR);
  localparam logic [6:0] LAST_A  = 7'(LAST_ADDR);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [6:0]  cnt_q, cnt_d;
  logic        if_end_q, if_end_d;
  logic [6:0]  address_q, address_d;
  logic        dump_valid_q, dump_valid_d;
  logic [31:0] dump_data_q, dump_data_d;
  logic [6:0]  dump_addr_q, dump_addr_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  // Next-state and next-output logic; every register holds unless a transition updates it.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    if_end_d     = if_end_q;
    address_d    = address_q;
    dump_valid_d = dump_valid_q;
    dump_data_d  = dump_data_q;
    dump_addr_d  = dump_addr_q;
    busy_d       = busy_q;
    done_d       = done_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = FETCH;
          cnt_d     = FIRST_A;
          address_d = FIRST_A;
          if_end_d  = 1'b1;
          busy_d    = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      FETCH: begin
        // The address was already registered on entry, so ReadDataM is settled here.
        dump_data_d  = ReadDataM;
        dump_addr_d  = cnt_q;
        dump_valid_d = 1'b1;
        state_d      = HOLD;
      end
      HOLD: begin
        if (dump_ready) begin
          dump_valid_d = 1'b0;
          if (cnt_q != LAST_A) begin
            cnt_d     = cnt_q + 7'd1;
            address_d = cnt_q + 7'd1;
            state_d   = FETCH;
          end else begin
            // Stop on the last index: the counter never increments past it.
            state_d = DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end else begin
          state_d = HOLD;
        end
      end
      DONE: begin
        state_d = DONE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; asynchronous reset clears everything to idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= 7'd0;
      if_end_q     <= 1'b0;
      address_q    <= 7'd0;
      dump_valid_q <= 1'b0;
      dump_data_q  <= 32'd0;
      dump_addr_q  <= 7'd0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      if_end_q     <= if_end_d;
      address_q    <= address_d;
      dump_valid_q <= dump_valid_d;
      dump_data_q  <= dump_data_d;
      dump_addr_q  <= dump_addr_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign if_end     = if_end_q;
  assign address    = address_q;
  assign dump_valid = dump_valid_q;
  assign dump_data  = dump_data_q;
  assign dump_addr  = dump_addr_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_mem_dump.sv
// Directed bench for mem_dump.
// u0 uses the full 0..127 range; u1 has FIRST_ADDR = LAST_ADDR = 5.
// Each DUT reads from a DRAM model where word[i] = 0xA5000000 + i.
module tb_mem_dump;

  logic        clk = 1'b0;
  logic        rst;
  logic        start0, start1;
  logic        ready0, ready1;
  logic [31:0] rdata0, rdata1;
  logic        if_end0, if_end1;
  logic [6:0]  address0, address1;
  logic        valid0, valid1;
  logic [31:0] data0, data1;
  logic [6:0]  daddr0, daddr1;
  logic        busy0, busy1;
  logic        done0, done1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign rdata0 = 32'hA500_0000 + {25'd0, address0};
  assign rdata1 = 32'hA500_0000 + {25'd0, address1};

  mem_dump u0 (
    .clk(clk), .rst(rst), .start(start0), .ReadDataM(rdata0), .dump_ready(ready0),
    .if_end(if_end0), .address(address0), .dump_valid(valid0), .dump_data(data0),
    .dump_addr(daddr0), .busy(busy0), .done(done0)
  );

  mem_dump #(.FIRST_ADDR(5), .LAST_ADDR(5)) u1 (
    .clk(clk), .rst(rst), .start(start1), .ReadDataM(rdata1), .dump_ready(ready1),
    .if_end(if_end1), .address(address1), .dump_valid(valid1), .dump_data(data1),
    .dump_addr(daddr1), .busy(busy1), .done(done1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero0(input string tag);
    chk({tag, ".if_end"}, {31'd0, if_end0}, 32'd0);
    chk({tag, ".address"}, {25'd0, address0}, 32'd0);
    chk({tag, ".valid"}, {31'd0, valid0}, 32'd0);
    chk({tag, ".data"}, data0, 32'd0);
    chk({tag, ".daddr"}, {25'd0, daddr0}, 32'd0);
    chk({tag, ".busy"}, {31'd0, busy0}, 32'd0);
    chk({tag, ".done"}, {31'd0, done0}, 32'd0);
  endtask

  initial begin
    logic [31:0] w;
    logic [31:0] hold_data;
    rst = 1'b1; start0 = 1'b0; start1 = 1'b0; ready0 = 1'b1; ready1 = 1'b1;
    #2;
    chk_zero0("reset");
    chk("reset.u1.if_end", {31'd0, if_end1}, 32'd0);
    tick();
    rst = 1'b0;

    // Idle with start low: if_end must stay 0.
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("idle.if_end", {31'd0, if_end0}, 32'd0);
      chk("idle.valid", {31'd0, valid0}, 32'd0);
    end

    // Single-word dump on u1.
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    chk("u1.fetch.address", {25'd0, address1}, 32'd5);
    chk("u1.fetch.if_end", {31'd0, if_end1}, 32'd1);
    chk("u1.fetch.busy", {31'd0, busy1}, 32'd1);
    tick();
    chk("u1.hold.valid", {31'd0, valid1}, 32'd1);
    chk("u1.hold.daddr", {25'd0, daddr1}, 32'd5);
    chk("u1.hold.data", data1, 32'hA500_0005);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("u1.done.done", {31'd0, done1}, 32'd1);
      chk("u1.done.valid", {31'd0, valid1}, 32'd0);
      chk("u1.done.address", {25'd0, address1}, 32'd5);
      chk("u1.done.if_end", {31'd0, if_end1}, 32'd1);
    end

    // Full dump on u0 with ready high; start wiggles mid-dump.
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    chk("a.fetch0.if_end", {31'd0, if_end0}, 32'd1);
    chk("a.fetch0.address", {25'd0, address0}, 32'd0);
    chk("a.fetch0.valid", {31'd0, valid0}, 32'd0);
    w = 32'd0;
    for (int cyc = 1; cyc <= 256; cyc++) begin
      tick();
      start0 = ((cyc % 7) == 0);
      chk("a.if_end", {31'd0, if_end0}, 32'd1);
      chk("a.done", {31'd0, done0}, (cyc == 256) ? 32'd1 : 32'd0);
      if ((cyc % 2) == 1) begin
        chk("a.valid", {31'd0, valid0}, 32'd1);
        chk("a.daddr", {25'd0, daddr0}, w);
        chk("a.data", data0, 32'hA500_0000 + w);
        w = w + 32'd1;
      end else begin
        chk("a.gap.valid", {31'd0, valid0}, 32'd0);
        chk("a.gap.address", {25'd0, address0}, (cyc == 256) ? 32'd127 : 32'(cyc / 2));
        chk("a.gap.busy", {31'd0, busy0}, (cyc == 256) ? 32'd0 : 32'd1);
      end
    end
    chk("a.word_count", w, 32'd128);

    // Start held high in DONE: no restart.
    start0 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("a.sticky.done", {31'd0, done0}, 32'd1);
      chk("a.sticky.valid", {31'd0, valid0}, 32'd0);
      chk("a.sticky.address", {25'd0, address0}, 32'd127);
      chk("a.sticky.if_end", {31'd0, if_end0}, 32'd1);
    end
    start0 = 1'b0;

    // Asynchronous reset in mid-cycle.
    #2 rst = 1'b1;
    #1 chk_zero0("rst_done");
    tick();
    rst = 1'b0;
    tick();
    chk("idle2.if_end", {31'd0, if_end0}, 32'd0);

    // Dump with a 10-cycle stall at word 3, reset during HOLD of word 40.
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    for (int wi = 0; wi <= 40; wi++) begin
      tick();
      chk("b.valid", {31'd0, valid0}, 32'd1);
      chk("b.daddr", {25'd0, daddr0}, 32'(wi));
      chk("b.data", data0, 32'hA500_0000 + 32'(wi));
      if (wi == 3) begin
        ready0 = 1'b0;
        hold_data = 32'hA500_0003;
        for (int s = 0; s < 10; s++) begin
          tick();
          chk("b.stall.valid", {31'd0, valid0}, 32'd1);
          chk("b.stall.daddr", {25'd0, daddr0}, 32'd3);
          chk("b.stall.data", data0, hold_data);
        end
        ready0 = 1'b1;
      end
      if (wi < 40) begin
        tick();
        chk("b.gap.valid", {31'd0, valid0}, 32'd0);
        chk("b.gap.address", {25'd0, address0}, 32'(wi + 1));
      end
    end
    ready0 = 1'b0;
    #2 rst = 1'b1;
    #1 chk_zero0("rst_hold40");
    tick();
    rst = 1'b0;
    ready0 = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("idle3.if_end", {31'd0, if_end0}, 32'd0);
      chk("idle3.valid", {31'd0, valid0}, 32'd0);
    end

    // Restart begins from word 0 again.
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    chk("c.fetch.address", {25'd0, address0}, 32'd0);
    tick();
    chk("c.valid", {31'd0, valid0}, 32'd1);
    chk("c.daddr", {25'd0, daddr0}, 32'd0);
    chk("c.data", data0, 32'hA500_0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_dump.md
MEM_DUMP -- requirements
Module: mem_dump

Interface
REQ-001 Parameter FIRST_ADDR, default 0, first DRAM word index dumped (0..127).
REQ-002 Parameter LAST_ADDR, default 127, last DRAM word index dumped (FIRST_ADDR..127).
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 start  input  1  level; sampled in IDLE only; CPU halt / end-of-program indication.
REQ-006 ReadDataM  input  32  DRAM read data (combinational read of address driven by this block).
REQ-007 dump_ready  input  1  consumer accepts current word when high at a rising edge with dump_valid high.
REQ-008 if_end  output  1  high = DRAM address mux selects this block's address instead of ALUOutM>>2.
REQ-009 address  output  7  DRAM word index driven to the memory stage.
REQ-010 dump_valid  output  1  dump_data/dump_addr hold a word not yet accepted.
REQ-011 dump_data  output  32  captured DRAM word.
REQ-012 dump_addr  output  7  word index of dump_data.
REQ-013 busy  output  1  high in FETCH or HOLD.
REQ-014 done  output  1  high in DONE.

Function
REQ-015 FSM states IDLE, FETCH, HOLD, DONE; all outputs registered.
REQ-016 IDLE: if_end=0, address=0, dump_valid=0; start=1 at edge -> FETCH, addr counter loaded with FIRST_ADDR, if_end=1.
REQ-017 FETCH (exactly one cycle): address=counter; at the edge dump_data<=ReadDataM, dump_addr<=counter, dump_valid<=1, -> HOLD.
REQ-018 HOLD: dump_valid, dump_data, dump_addr stable until dump_ready=1 sampled at an edge; no change while dump_ready=0, indefinitely.
REQ-019 HOLD accept with counter != LAST_ADDR: dump_valid<=0, counter<=counter+1, -> FETCH.
REQ-020 HOLD accept with counter == LAST_ADDR: dump_valid<=0, -> DONE; counter not incremented (no 7-bit wrap ever occurs).
REQ-021 DONE: if_end=1, address holds LAST_ADDR, done=1, dump_valid=0; sticky until rst.
REQ-022 if_end SHALL be 1 in FETCH, HOLD, DONE and 0 only in IDLE; it rises at the same edge FETCH is entered.
REQ-023 start ignored outside IDLE; start deasserting mid-dump has no effect.
REQ-024 dump_ready while dump_valid=0 ignored.
REQ-025 Latency: start sampled at edge k -> dump_valid high after edge k+1; with dump_ready tied high, one word per 2 cycles.
REQ-026 FIRST_ADDR == LAST_ADDR: exactly one word emitted, then DONE.
REQ-027 Total words emitted per dump = LAST_ADDR-FIRST_ADDR+1, each exactly once, strictly ascending dump_addr.

Reset
REQ-028 rst=1 SHALL immediately (no clock) force IDLE, counter=0, if_end=0, address=0, dump_valid=0, dump_data=0, dump_addr=0, busy=0, done=0.
REQ-029 rst asserted mid-dump aborts; after release block waits in IDLE for start; no partial word presented.

Verification
REQ-030 DRAM model word[i]=0xA5000000+i, defaults, dump_ready=1, start pulse -> 128 words, dump_addr 0..127 ascending, dump_data matches, done=1 after 256 cycles from FETCH entry.
REQ-031 FIRST_ADDR=5, LAST_ADDR=5 -> single word dump_addr=5, data 0xA5000005, then DONE, address stays 5.
REQ-032 dump_ready low for 10 cycles at word 3 -> dump_valid/dump_data/dump_addr=3 constant for all 10 cycles, no word skipped or duplicated.
REQ-033 rst pulsed during HOLD of word 40 -> outputs zero asynchronously, if_end=0; new start restarts from FIRST_ADDR=0.
REQ-034 start toggled during dump and held high in DONE -> no restart, no extra words, done stays 1.
REQ-035 Check if_end=0 throughout IDLE before start and 1 continuously from FETCH entry to end of test.
